// File: rtl/brg_arb_pkg.sv
// Shared types and constants for the SWD bridge arbiter.
// Holds the FSM state encoding, SWD ACK codes and the latched command record.
package brg_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_COMPLETE,
        ST_HOLD
    } state_t;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    typedef struct packed {
        logic        apndp;
        logic        rnw;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

endpackage

// File: rtl/brg_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, wrapping around, and flags whether anyone was requesting at all.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             valid
);

    int idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/brg_arbiter.sv
// Shares the single SWD bridge engine between N_REQ requesters, one DP/AP
// transfer at a time, with round-robin fairness, optional lock and timeout.
module brg_arbiter
    import brg_arb_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int TIMEOUT       = 4096,
    parameter int LOCK_IDLE_MAX = 256
) (
    input  logic                hclk,
    input  logic                RESETn,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_apndp,
    input  logic [N_REQ-1:0]    req_rnw,
    input  logic [N_REQ*2-1:0]  req_addr,
    input  logic [N_REQ*32-1:0] req_wdata,
    input  logic [N_REQ-1:0]    req_lock,
    output logic [N_REQ-1:0]    req_done,
    output logic [31:0]         req_rdata,
    output logic [2:0]          req_ack,
    output logic                req_tmo,
    output logic [N_REQ-1:0]    grant,
    output logic                brg_valid,
    output logic                brg_apndp,
    output logic                brg_rnw,
    output logic [1:0]          brg_addr,
    output logic [31:0]         brg_wdata,
    input  logic                brg_ready,
    input  logic                brg_done,
    input  logic [31:0]         brg_rdata,
    input  logic [2:0]          brg_ack,
    output logic                brg_abort
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int IW = $clog2(LOCK_IDLE_MAX) + 1;

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_in;
    logic [PW-1:0]    rr_ptr, owner_q, pick_idx, src_idx;
    logic [N_REQ-1:0] pick_gnt;
    logic             pick_valid;
    logic             lock_q;
    logic [TW-1:0]    timer;
    logic [IW-1:0]    idle_cnt;
    logic             load_cmd, accept, done_ok, done_tmo, release_bus, hold_idle;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // In HOLD only the current owner may reload the bridge command.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick_gnt[i]) pick_idx = PW'(i);
        src_idx      = (state_q == ST_HOLD) ? owner_q : pick_idx;
        cmd_in.apndp = req_apndp[src_idx];
        cmd_in.rnw   = req_rnw[src_idx];
        cmd_in.addr  = req_addr[int'(src_idx)*2 +: 2];
        cmd_in.wdata = req_wdata[int'(src_idx)*32 +: 32];
    end

    always_ff @(posedge hclk) begin
        if (!RESETn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        load_cmd    = 1'b0;
        accept      = 1'b0;
        done_ok     = 1'b0;
        done_tmo    = 1'b0;
        release_bus = 1'b0;
        hold_idle   = 1'b0;
        case (state_q)
            ST_IDLE: if (pick_valid) begin
                load_cmd = 1'b1;
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: if (brg_ready) begin
                accept  = 1'b1;
                state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (brg_done) begin
                    done_ok = 1'b1;
                    state_d = ST_COMPLETE;
                end else if (timer == TW'(TIMEOUT-1)) begin
                    done_tmo = 1'b1;
                    state_d  = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                if (lock_q) begin
                    state_d = ST_HOLD;
                end else begin
                    release_bus = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (req_valid[owner_q]) begin
                    load_cmd = 1'b1;
                    state_d  = ST_ISSUE;
                end else if (idle_cnt == IW'(LOCK_IDLE_MAX-1)) begin
                    release_bus = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    hold_idle = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A timeout clears the lock so the COMPLETE cycle always releases the bridge.
    always_ff @(posedge hclk) begin
        if (!RESETn) begin
            cmd_q     <= '0;
            brg_valid <= 1'b0;
            brg_abort <= 1'b0;
            grant     <= '0;
            owner_q   <= '0;
            rr_ptr    <= '0;
            lock_q    <= 1'b0;
            timer     <= '0;
            idle_cnt  <= '0;
            req_done  <= '0;
            req_rdata <= '0;
            req_ack   <= '0;
            req_tmo   <= 1'b0;
        end else begin
            req_done  <= '0;
            brg_abort <= 1'b0;
            if (load_cmd) begin
                cmd_q     <= cmd_in;
                brg_valid <= 1'b1;
                owner_q   <= src_idx;
                lock_q    <= req_lock[src_idx];
                if (state_q == ST_IDLE) grant <= pick_gnt;
            end
            if (accept) begin
                brg_valid <= 1'b0;
                timer     <= '0;
            end
            if (state_q == ST_WAIT_RSP && !done_ok && !done_tmo && timer != '1)
                timer <= timer + 1'b1;
            if (done_ok) begin
                req_done[owner_q] <= 1'b1;
                req_rdata         <= brg_rdata;
                req_ack           <= brg_ack;
                req_tmo           <= 1'b0;
            end
            if (done_tmo) begin
                req_done[owner_q] <= 1'b1;
                req_rdata         <= '0;
                req_ack           <= '0;
                req_tmo           <= 1'b1;
                brg_abort         <= 1'b1;
                lock_q            <= 1'b0;
            end
            if (state_q == ST_COMPLETE) idle_cnt <= '0;
            if (hold_idle) idle_cnt <= idle_cnt + 1'b1;
            if (release_bus) begin
                grant  <= '0;
                rr_ptr <= (owner_q == PW'(N_REQ-1)) ? '0 : owner_q + 1'b1;
            end
        end
    end

    assign brg_apndp = cmd_q.apndp;
    assign brg_rnw   = cmd_q.rnw;
    assign brg_addr  = cmd_q.addr;
    assign brg_wdata = cmd_q.wdata;

endmodule
